// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter for a single shared memory bus, with
// round-robin tie-breaking, flush-suppressed acks and a per-transaction timeout.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fe_req,
   input  logic [31:0] fe_addr,
   output logic        fe_ack,
   output logic [31:0] fe_data,
   input  logic        mem_req,
   input  logic [31:0] mem_addr,
   input  logic        mem_write,
   input  logic [31:0] mem_wdata,
   input  logic        mem_extend,
   input  logic [1:0]  mem_width,
   output logic        mem_ack,
   output logic [31:0] mem_rdata,
   output logic        bus_req,
   output logic [31:0] bus_addr,
   output logic        bus_write,
   output logic [31:0] bus_wdata,
   output logic        bus_extend,
   output logic [1:0]  bus_width,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        err
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW:0] TO_VAL = (CW + 1)'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FE_BUSY  = 2'd1,
      MEM_BUSY = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          last_fe_q, last_fe_d;
   logic          abort_q, abort_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic [31:0]   addr_q, addr_d;
   logic          write_q, write_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          extend_q, extend_d;
   logic [1:0]    width_q, width_d;

   logic [CW:0]   cnt_inc;
   logic          owner_req;

   assign cnt_inc   = {1'b0, cnt_q} + 1'b1;
   assign owner_req = (state_q == FE_BUSY) ? fe_req : mem_req;

   // Ack only reaches a requester that still holds its request and never dropped it.
   assign fe_ack    = (state_q == FE_BUSY) && bus_ack && fe_req && !abort_q;
   assign mem_ack   = (state_q == MEM_BUSY) && bus_ack && mem_req && !abort_q;
   assign fe_data   = fe_ack  ? bus_rdata : 32'd0;
   assign mem_rdata = mem_ack ? bus_rdata : 32'd0;

   assign bus_req    = (state_q != IDLE);
   assign bus_addr   = addr_q;
   assign bus_write  = write_q;
   assign bus_wdata  = wdata_q;
   assign bus_extend = extend_q;
   assign bus_width  = width_q;
   assign err        = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         last_fe_q <= 1'b1;
         abort_q   <= 1'b0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         addr_q    <= 32'd0;
         write_q   <= 1'b0;
         wdata_q   <= 32'd0;
         extend_q  <= 1'b0;
         width_q   <= 2'b00;
      end else begin
         state_q   <= state_d;
         last_fe_q <= last_fe_d;
         abort_q   <= abort_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         extend_q  <= extend_d;
         width_q   <= width_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_fe_d = last_fe_q;
      abort_d   = abort_q;
      cnt_d     = cnt_q;
      err_d     = 1'b0;
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      extend_d  = extend_q;
      width_d   = width_q;
      case (state_q)
         IDLE: begin
            // On a tie the data side wins unless it was the last one granted.
            if (mem_req && (!fe_req || last_fe_q)) begin
               state_d   = MEM_BUSY;
               last_fe_d = 1'b0;
               abort_d   = 1'b0;
               cnt_d     = '0;
               addr_d    = mem_addr;
               write_d   = mem_write;
               wdata_d   = mem_wdata;
               extend_d  = mem_extend;
               width_d   = mem_width;
            end else if (fe_req) begin
               state_d   = FE_BUSY;
               last_fe_d = 1'b1;
               abort_d   = 1'b0;
               cnt_d     = '0;
               addr_d    = fe_addr;
               write_d   = 1'b0;
               wdata_d   = 32'd0;
               extend_d  = 1'b0;
               width_d   = 2'b10;
            end
         end
         FE_BUSY, MEM_BUSY: begin
            // A completion in the final allowed cycle wins over the timeout.
            if (bus_ack) begin
               state_d = IDLE;
               abort_d = 1'b0;
            end else if (cnt_inc == TO_VAL) begin
               state_d = IDLE;
               abort_d = 1'b0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_inc[CW-1:0];
               if (!owner_req) abort_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_mem_arbiter;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fe_req = 1'b0;
   logic [31:0] fe_addr = 32'd0;
   logic        fe_ack;
   logic [31:0] fe_data;
   logic        mem_req = 1'b0;
   logic [31:0] mem_addr = 32'd0;
   logic        mem_write = 1'b0;
   logic [31:0] mem_wdata = 32'd0;
   logic        mem_extend = 1'b0;
   logic [1:0]  mem_width = 2'b00;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        bus_req;
   logic [31:0] bus_addr;
   logic        bus_write;
   logic [31:0] bus_wdata;
   logic        bus_extend;
   logic [1:0]  bus_width;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'd0;
   logic        err;

   int checks = 0;
   int errors = 0;
   int fe_pulses = 0;
   int mem_pulses = 0;

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .fe_req(fe_req), .fe_addr(fe_addr), .fe_ack(fe_ack), .fe_data(fe_data),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_extend(mem_extend), .mem_width(mem_width),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .bus_req(bus_req), .bus_addr(bus_addr), .bus_write(bus_write),
      .bus_wdata(bus_wdata), .bus_extend(bus_extend), .bus_width(bus_width),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .err(err)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: owner 0=none 1=fetch 2=data
   int          m_owner, m_age;
   bit          m_flushed, m_err, m_prefer_mem;
   logic [31:0] m_addr, m_wdata;
   logic        m_write, m_extend;
   logic [1:0]  m_width;
   int          grant_log[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_owner <= 0; m_age <= 0; m_flushed <= 0; m_err <= 0; m_prefer_mem <= 1;
         m_addr <= 0; m_wdata <= 0; m_write <= 0; m_extend <= 0; m_width <= 0;
      end else begin
         m_err <= 0;
         if (m_owner == 0) begin
            if (mem_req && (!fe_req || m_prefer_mem)) begin
               m_owner <= 2; m_prefer_mem <= 0; grant_log.push_back(2);
               m_addr <= mem_addr; m_write <= mem_write; m_wdata <= mem_wdata;
               m_extend <= mem_extend; m_width <= mem_width;
               m_age <= 0; m_flushed <= 0;
            end else if (fe_req) begin
               m_owner <= 1; m_prefer_mem <= 1; grant_log.push_back(1);
               m_addr <= fe_addr; m_write <= 0; m_wdata <= 0;
               m_extend <= 0; m_width <= 2'b10;
               m_age <= 0; m_flushed <= 0;
            end
         end else if (bus_ack) begin
            m_owner <= 0; m_flushed <= 0;
         end else if (m_age + 1 == int'(TO)) begin
            m_owner <= 0; m_flushed <= 0; m_err <= 1;
         end else begin
            m_age <= m_age + 1;
            if (!((m_owner == 1) ? fe_req : mem_req)) m_flushed <= 1;
         end
      end
   end

   // scoreboard compare, every cycle on the falling edge
   always @(negedge clk) begin
      logic e_fe, e_mem;
      e_fe  = (m_owner == 1) && bus_ack && fe_req && !m_flushed;
      e_mem = (m_owner == 2) && bus_ack && mem_req && !m_flushed;
      chk("m_bus_req", bus_req, (m_owner != 0));
      chk("m_bus_addr", bus_addr, m_addr);
      chk("m_bus_write", bus_write, m_write);
      chk("m_bus_wdata", bus_wdata, m_wdata);
      chk("m_bus_extend", bus_extend, m_extend);
      chk("m_bus_width", bus_width, m_width);
      chk("m_fe_ack", fe_ack, e_fe);
      chk("m_fe_data", fe_data, e_fe ? bus_rdata : 32'd0);
      chk("m_mem_ack", mem_ack, e_mem);
      chk("m_mem_rdata", mem_rdata, e_mem ? bus_rdata : 32'd0);
      chk("m_err", err, m_err);
      if (fe_ack === 1'b1) fe_pulses++;
      if (mem_ack === 1'b1) mem_pulses++;
   end

   // driver tasks
   task automatic do_reset();
      reset = 1'b1;
      fe_req = 0; mem_req = 0; bus_ack = 0; bus_rdata = 0;
      mem_write = 0; mem_extend = 0; mem_width = 0; mem_wdata = 0;
      repeat (2) @(posedge clk);
      chk("rst_bus_req", bus_req, 0);
      chk("rst_bus_addr", bus_addr, 0);
      #1 reset = 1'b0;
      fe_pulses = 0; mem_pulses = 0;
   endtask

   task automatic wait_grant(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (bus_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(name, bus_req, 1);
   endtask

   // Called at the negedge of the first busy cycle; returns at the negedge of the ack cycle.
   task automatic ack_after(input int n, input logic [31:0] rdata);
      repeat (n) @(posedge clk);
      #1 bus_ack = 1'b1; bus_rdata = rdata;
      @(negedge clk);
   endtask

   task automatic finish_ack(input bit drop_fe, input bit drop_mem);
      @(posedge clk);
      #1 bus_ack = 1'b0; bus_rdata = 0;
      if (drop_fe) fe_req = 0;
      if (drop_mem) mem_req = 0;
   endtask

   initial begin
      // fetch read, ack two cycles after bus_req
      do_reset();
      fe_req = 1; fe_addr = 32'h100;
      wait_grant("t1_grant");
      ack_after(2, 32'h0000_0013);
      chk("t1_fe_ack", fe_ack, 1);
      chk("t1_fe_data", fe_data, 32'h13);
      chk("t1_bus_addr", bus_addr, 32'h100);
      chk("t1_bus_write", bus_write, 0);
      chk("t1_mem_ack", mem_ack, 0);
      finish_ack(1, 0);
      repeat (2) @(negedge clk);
      chk("t1_fe_pulses", fe_pulses, 1);

      // simultaneous requests out of reset: data side first
      do_reset();
      fe_req = 1; fe_addr = 32'h104;
      mem_req = 1; mem_addr = 32'h200; mem_write = 1; mem_wdata = 32'hDEADBEEF; mem_width = 2'b10;
      wait_grant("t2_grant_mem");
      chk("t2_bus_write", bus_write, 1);
      chk("t2_bus_wdata", bus_wdata, 32'hDEADBEEF);
      chk("t2_bus_addr", bus_addr, 32'h200);
      ack_after(1, 32'h0);
      chk("t2_mem_ack", mem_ack, 1);
      chk("t2_fe_ack_blocked", fe_ack, 0);
      finish_ack(0, 1);
      @(negedge clk);
      chk("t2_idle_gap", bus_req, 0);
      wait_grant("t2_grant_fe");
      chk("t2_fe_addr", bus_addr, 32'h104);
      chk("t2_fe_width", bus_width, 2'b10);
      chk("t2_fe_write", bus_write, 0);
      ack_after(1, 32'h1234_5678);
      chk("t2_fe_data", fe_data, 32'h1234_5678);
      finish_ack(1, 0);

      // both held over four transactions: strict alternation
      do_reset();
      grant_log.delete();
      fe_req = 1; fe_addr = 32'h180;
      mem_req = 1; mem_addr = 32'h280; mem_write = 1; mem_wdata = 32'h5A5A_0000;
      for (int i = 0; i < 4; i++) begin
         wait_grant("t3_grant");
         chk("t3_owner_write", bus_write, (i % 2 == 0) ? 32'd1 : 32'd0);
         ack_after(1, 32'h10 + i);
         finish_ack(0, 0);
      end
      fe_req = 0; mem_req = 0;
      @(negedge clk);
      chk("t3_grant_count", grant_log.size(), 4);
      if (grant_log.size() == 4) begin
         chk("t3_order0", grant_log[0], 2);
         chk("t3_order1", grant_log[1], 1);
         chk("t3_order2", grant_log[2], 2);
         chk("t3_order3", grant_log[3], 1);
      end

      // fetch flushed before completion, then served normally
      do_reset();
      fe_req = 1; fe_addr = 32'h300;
      wait_grant("t4_grant");
      @(posedge clk);
      #1 fe_req = 0;
      @(posedge clk);
      #1 bus_ack = 1; bus_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      chk("t4_flush_ack", fe_ack, 0);
      chk("t4_flush_data", fe_data, 0);
      finish_ack(0, 0);
      fe_req = 1; fe_addr = 32'h304;
      wait_grant("t4_regrant");
      chk("t4_addr", bus_addr, 32'h304);
      ack_after(1, 32'h55);
      chk("t4_fe_data", fe_data, 32'h55);
      finish_ack(1, 0);
      @(negedge clk);
      chk("t4_fe_pulses", fe_pulses, 1);

      // ack in the last allowed cycle counts as completion
      do_reset();
      mem_req = 1; mem_addr = 32'h500; mem_extend = 1; mem_width = 2'b01;
      wait_grant("t7_grant");
      ack_after(TO - 1, 32'hFFFF_8000);
      chk("t7_mem_ack", mem_ack, 1);
      chk("t7_mem_rdata", mem_rdata, 32'hFFFF_8000);
      chk("t7_extend", bus_extend, 1);
      chk("t7_width", bus_width, 2'b01);
      finish_ack(0, 1);
      @(negedge clk);
      chk("t7_no_err", err, 0);
      chk("t7_idle", bus_req, 0);

      // timeout with no bus_ack, then async reset while busy
      do_reset();
      mem_req = 1; mem_addr = 32'h400;
      wait_grant("t5_grant");
      repeat (TO - 1) @(negedge clk);
      chk("t5_busy_last", bus_req, 1);
      chk("t5_err_early", err, 0);
      @(negedge clk);
      chk("t5_err", err, 1);
      chk("t5_bus_req", bus_req, 0);
      chk("t5_mem_ack", mem_ack, 0);
      @(negedge clk);
      chk("t5_err_pulse", err, 0);
      chk("t5_regrant", bus_req, 1);
      #2 reset = 1'b1;
      #1;
      chk("t6_bus_req", bus_req, 0);
      chk("t6_bus_addr", bus_addr, 0);
      chk("t6_bus_width", bus_width, 0);
      chk("t6_err", err, 0);
      chk("t6_mem_ack", mem_ack, 0);
      mem_req = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      bus_ack = 1; bus_rdata = 32'hABCD;
      @(negedge clk);
      chk("t6_stale_mem_ack", mem_ack, 0);
      chk("t6_stale_fe_ack", fe_ack, 0);
      chk("t6_stale_rdata", mem_rdata, 0);
      @(posedge clk);
      #1 bus_ack = 0;
      @(negedge clk);
      chk("t6_idle", bus_req, 0);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation did not finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles a granted bus transaction may wait for bus_ack (range 1..65535).
REQ-002 SHALL have ports:
- clk, in, 1, sole clock; all state updates on rising edge.
- reset, in, 1, asynchronous active-high reset.
- fe_req, in, 1, fetch read request, level, held until fe_ack.
- fe_addr, in, 32, fetch address.
- fe_ack, out, 1, one-cycle fetch completion pulse.
- fe_data, out, 32, fetch read data, valid with fe_ack.
- mem_req, in, 1, data request, level, held until mem_ack.
- mem_addr, in, 32, data address.
- mem_write, in, 1, 1=store, 0=load.
- mem_wdata, in, 32, store data.
- mem_extend, in, 1, load sign-extend.
- mem_width, in, 2, access width code.
- mem_ack, out, 1, one-cycle data completion pulse.
- mem_rdata, out, 32, load data, valid with mem_ack.
- bus_req, out, 1, shared memory request, level.
- bus_addr, out, 32; bus_write, out, 1; bus_wdata, out, 32; bus_extend, out, 1; bus_width, out, 2: latched request fields.
- bus_ack, in, 1, one-cycle completion pulse from memory.
- bus_rdata, in, 32, read data, valid with bus_ack.
- err, out, 1, one-cycle timeout pulse.

Function
REQ-003 SHALL implement FSM states IDLE, FE_BUSY, MEM_BUSY.
REQ-004 In IDLE, when only fe_req=1, SHALL latch fe_addr, bus_write=0, bus_wdata=0, bus_extend=0, bus_width=2'b10, and enter FE_BUSY.
REQ-005 In IDLE, when only mem_req=1, SHALL latch all mem_* fields and enter MEM_BUSY.
REQ-006 In IDLE with both requests, SHALL grant the requester not granted last (round-robin); last-grant register resets to fe, so mem wins the first tie.
REQ-007 bus_req SHALL be 1 exactly in FE_BUSY/MEM_BUSY; bus_* fields SHALL be registers, stable for the whole transaction.
REQ-008 Grant latency: request seen in IDLE at edge N -> bus_req=1 from cycle N+1.
REQ-009 bus_ack in FE_BUSY SHALL drive fe_ack=1 and fe_data=bus_rdata combinationally that cycle; in MEM_BUSY likewise mem_ack/mem_rdata.
REQ-010 On bus_ack the FSM SHALL return to IDLE; the next grant SHALL take at least one IDLE cycle (bus_req low for >=1 cycle between transactions).
REQ-011 fe_data/mem_rdata SHALL be 0 when the corresponding ack is 0.
REQ-012 bus_ack in IDLE SHALL be ignored (no ack, no state change).
REQ-013 If the granted requester drops its req before bus_ack (flush), the transaction SHALL complete on the bus but the ack to that requester SHALL be suppressed; an abort flag records this and clears on return to IDLE.
REQ-014 SHALL count cycles in a busy state with a counter sized for TIMEOUT; counter clears on each grant.
REQ-015 When the counter reaches TIMEOUT without bus_ack, SHALL pulse err=1 for one cycle, assert no requester ack, and return to IDLE.
REQ-016 bus_ack in the same cycle the counter reaches TIMEOUT SHALL count as completion: normal ack, err=0.
REQ-017 The non-granted requester SHALL never see an ack; its pending request is served at the next IDLE.

Reset
REQ-018 reset=1 SHALL immediately force IDLE, last-grant=fe, abort=0, counter=0, and bus_req, bus_addr, bus_write, bus_wdata, bus_extend, bus_width, fe_ack, mem_ack, err, fe_data, mem_rdata all 0.
REQ-019 Reset asserted mid-transaction SHALL abandon it without any ack; a bus_ack arriving after reset release in IDLE is ignored per REQ-012.

Verification
REQ-020 fe_req=1, fe_addr=0x100, bus_ack 2 cycles after bus_req with bus_rdata=0x00000013 -> bus_addr=0x100, bus_write=0, fe_ack one pulse, fe_data=0x00000013, mem_ack=0.
REQ-021 fe_req and mem_req both rise same cycle out of reset (mem store 0x200, data 0xDEADBEEF, width 2'b10) -> mem served first with bus_write=1, bus_wdata=0xDEADBEEF; then fe served after one idle cycle.
REQ-022 Both requests held continuously over 4 transactions -> grant order mem, fe, mem, fe.
REQ-023 fe granted, fe_req dropped before bus_ack -> bus transaction completes, fe_ack stays 0, next fe request served normally.
REQ-024 TIMEOUT=4, mem granted, bus_ack never asserted -> err pulses one cycle after 4 busy cycles, mem_ack=0, FSM IDLE, bus_req=0.
REQ-025 reset asserted while MEM_BUSY -> all outputs 0 asynchronously; stale bus_ack after release produces no ack.
